multi_space_meter: RTL and testbench

MULTI_SPACE_METER -- requirements
Module: multi_space_meter

---
 rtl/multi_space_meter.sv | 101 ++++++++++
 tb/tb_multi_space_meter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/multi_space_meter.sv
// multi_space_meter: multi-channel BCD parking meter with coin adds, presets, per-second countdown and blink status
module multi_space_meter #(
    parameter int DIGITS = 4,
    parameter int SPACES = 2,
    parameter logic [4*DIGITS-1:0] LOW_THRESH = 'h0060,
    parameter int SELW = (SPACES > 1) ? $clog2(SPACES) : 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  tick,
    input  logic [SELW-1:0]       space_sel,
    input  logic                  ad30,
    input  logic                  ad120,
    input  logic                  ad180,
    input  logic                  ad300,
    input  logic                  rs15,
    input  logic                  rs185,
    input  logic [SELW-1:0]       rd_sel,
    output logic [4*DIGITS-1:0]   Qout,
    output logic [SPACES-1:0]     expired,
    output logic [SPACES-1:0]     low,
    output logic [SPACES-1:0]     blink,
    output logic                  sat_pulse
);
    localparam int W = 4*DIGITS;
    localparam logic [SELW:0] NS = SPACES[SELW:0];

    logic [SPACES-1:0][W-1:0] t, nxt;
    logic phase;
    logic valid, preset, coin, hit;
    logic [W-1:0] cur, amt, res;
    logic [W:0] sum;

    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0] s;
        logic cy;
        cy = 1'b0;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            s = {1'b0, a[4*d+:4]} + {1'b0, b[4*d+:4]} + {4'b0, cy};
            cy = s > 5'd9;
            r[4*d+:4] = cy ? 4'(s - 5'd10) : s[3:0];
        end
        return {cy, r};
    endfunction

    // only called on nonzero values, so the final borrow never propagates out
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] a);
        logic [W-1:0] r;
        logic [3:0] dg;
        logic bw;
        bw = 1'b1;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dg = a[4*d+:4];
            r[4*d+:4] = (bw && dg == 4'd0) ? 4'd9 : dg - {3'b0, bw};
            bw = bw && dg == 4'd0;
        end
        return r;
    endfunction

    always_comb begin
        valid = {1'b0, space_sel} < NS;
        preset = rs185 | rs15;
        coin = ad30 | ad120 | ad180 | ad300;
        hit = valid && (preset || coin);
        amt = ad30 ? W'(12'h030) : ad120 ? W'(12'h120) : ad180 ? W'(12'h180) : W'(12'h300);
        cur = valid ? t[space_sel] : '0;
        sum = bcd_add(cur, amt);
        res = rs185 ? W'(12'h185) : rs15 ? W'(12'h015) : sum[W] ? {DIGITS{4'h9}} : sum[W-1:0];
        nxt = t;
        for (int i = 0; i < SPACES; i++) begin
            if (hit && space_sel == SELW'(i))
                nxt[i] = res;
            else if (tick && t[i] != '0)
                nxt[i] = bcd_dec(t[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            t <= '0;
            phase <= 1'b0;
            sat_pulse <= 1'b0;
        end else begin
            t <= nxt;
            phase <= phase ^ tick;
            sat_pulse <= valid && !preset && coin && sum[W];
        end
    end

    always_comb begin
        Qout = ({1'b0, rd_sel} < NS) ? t[rd_sel] : '0;
        for (int i = 0; i < SPACES; i++) begin
            expired[i] = t[i] == '0;
            low[i] = t[i] != '0 && t[i] < LOW_THRESH;
            blink[i] = expired[i] | (low[i] & phase);
        end
    end
endmodule

// File: tb/tb_multi_space_meter.sv
// tb_multi_space_meter: randomized and directed checks against an integer-seconds reference model
module tb_multi_space_meter;
    logic CLK = 1'b0, RST_N = 1'b0, tick = 1'b0;
    logic sel = 1'b0, rd = 1'b0;
    logic [5:0] c = 6'd0;
    logic [15:0] Qout;
    logic [1:0] expired, low, blink;
    logic sat_pulse;
    int checks = 0, failures = 0;
    int tm [2];
    bit ph, sp;

    localparam logic [5:0] RS185 = 6'b100000, RS15 = 6'b010000, AD30 = 6'b001000,
                           AD120 = 6'b000100, AD180 = 6'b000010, AD300 = 6'b000001;

    always #5 CLK = ~CLK;

    multi_space_meter dut (
        .CLK(CLK), .RST_N(RST_N), .tick(tick), .space_sel(sel),
        .ad30(c[3]), .ad120(c[2]), .ad180(c[1]), .ad300(c[0]),
        .rs15(c[4]), .rs185(c[5]), .rd_sel(rd),
        .Qout(Qout), .expired(expired), .low(low), .blink(blink), .sat_pulse(sat_pulse)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int d = 0; d < 4; d++) begin
            r[4*d+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [1:0] e, l, b;
        for (int r = 0; r < 2; r++) begin
            rd = r[0];
            #1;
            chk(r == 0 ? "qout0" : "qout1", Qout, to_bcd(tm[r]));
            e[r] = tm[r] == 0;
            l[r] = tm[r] > 0 && tm[r] < 60;
            b[r] = e[r] ? 1'b1 : l[r] ? ph : 1'b0;
        end
        chk("expired", {14'd0, expired}, {14'd0, e});
        chk("low", {14'd0, low}, {14'd0, l});
        chk("blink", {14'd0, blink}, {14'd0, b});
        chk("sat_pulse", {15'd0, sat_pulse}, {15'd0, sp});
    endtask

    task automatic cycle();
        int nt [2];
        int amt;
        bit nsp;
        nsp = 0;
        nt = tm;
        for (int i = 0; i < 2; i++) begin
            if (c != 6'd0 && sel == i[0]) begin
                if (c[5]) nt[i] = 185;
                else if (c[4]) nt[i] = 15;
                else begin
                    amt = c[3] ? 30 : c[2] ? 120 : c[1] ? 180 : 300;
                    nt[i] = tm[i] + amt;
                    if (nt[i] > 9999) begin
                        nt[i] = 9999;
                        nsp = 1;
                    end
                end
            end else if (tick && tm[i] > 0) nt[i] = tm[i] - 1;
        end
        @(posedge CLK);
        #1;
        tm = nt;
        sp = nsp;
        if (tick) ph = ~ph;
        check_all();
        c = 6'd0;
        tick = 1'b0;
    endtask

    task automatic cmd(input logic s, input logic [5:0] v, input logic t);
        sel = s;
        c = v;
        tick = t;
        cycle();
    endtask

    task automatic do_reset();
        #1 RST_N = 1'b0;
        #1;
        tm = '{0, 0};
        ph = 0;
        sp = 0;
        check_all();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        tm = '{0, 0};
        ph = 0;
        sp = 0;
        #2;
        do_reset();
        cmd(0, AD30, 0);
        chk("first_ad30", Qout, (rd == 1'b0) ? 16'h0030 : 16'h0000);
        cmd(1, RS185, 0);
        cmd(1, AD300, 0);
        repeat (5) cmd(0, 6'd0, 1);
        rd = 1'b1;
        #1 chk("s1_0480", Qout, 16'h0480);
        repeat (34) cmd(0, AD300, 0);
        rd = 1'b0;
        #1 chk("sat_hold", Qout, 16'h9999);
        chk("sat_flag", {15'd0, sat_pulse}, 16'd1);
        cmd(0, AD30 | RS15, 0);
        cmd(0, AD120, 0);
        cmd(0, AD180, 0);
        do_reset();
        cmd(1, RS185, 0);
        repeat (71) cmd(0, 6'd0, 1);
        cmd(0, RS15, 0);
        repeat (14) cmd(0, 6'd0, 1);
        cmd(0, AD30, 1);
        rd = 1'b0;
        #1 chk("tick_cmd_s0", Qout, 16'h0031);
        rd = 1'b1;
        #1 chk("tick_cmd_s1", Qout, 16'h0099);
        cmd(0, RS15, 0);
        repeat (16) cmd(0, 6'd0, 1);
        cmd(0, RS185, 0);
        cmd(1, RS185, 0);
        do_reset();
        repeat (600) begin
            sel = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            tick = ($urandom_range(0, 3) == 0);
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
